// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch unit.
package if_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        FETCH  = 2'd1,
        HALTED = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    // Instruction addresses are always word aligned; low two bits are dropped.
    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_prefetch_fifo.sv
// Prefetch FIFO holding fetched {pc, instr} pairs. Registered storage with
// wrap-around pointers; the head is visible the cycle after a push. When
// empty, the head output holds the last value that was presented.
module if_prefetch_fifo
    import if_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type entry_t = fetch_entry_t
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  entry_t                 push_data,
    input  logic                   pop,
    input  logic                   flush,
    output entry_t                 head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    entry_t          mem [DEPTH];
    entry_t          hold_q;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count_d;
    logic            push_en;
    logic            pop_en;

    assign empty = (count == '0);
    assign full  = (count == CW'(DEPTH));

    // A flush discards everything, including any pop requested that cycle.
    assign pop_en  = pop && !empty && !flush;
    assign push_en = push && !flush && (!full || pop_en);

    // Occupancy update: flush clears, simultaneous push and pop leave it unchanged.
    always_comb begin
        count_d = count;
        if (flush) begin
            count_d = '0;
        end else if (push_en && !pop_en) begin
            count_d = count + 1'b1;
        end else if (!push_en && pop_en) begin
            count_d = count - 1'b1;
        end
    end

    // Pointers and occupancy register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            count <= count_d;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_en) wr_ptr <= wr_ptr + 1'b1;
                if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Entry storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push_en) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Remember the presented head so the outputs hold steady while empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
        end else if (!empty) begin
            hold_q <= mem[rd_ptr];
        end
    end

    // Head selection: live entry when occupied, last presented entry otherwise.
    always_comb begin
        head = hold_q;
        if (!empty) head = mem[rd_ptr];
    end

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: owns the PC, drives the combinational instruction
// memory, buffers fetched words in a prefetch FIFO and hands them to decode
// over valid/ready. Accepts single-cycle redirects from execute.
//
// Handshake: decode takes the head entry on any rising edge where
// out_valid && out_ready; out_valid never depends on out_ready, and
// out_pc/out_instr stay stable while out_valid is high and not accepted.
module inst_fetch_unit
    import if_pkg::*;
#(
    parameter int              XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter int              FIFO_DEPTH = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic [XLEN-1:0]             imem_addr,
    output logic                        imem_req,
    input  logic [XLEN-1:0]             imem_rdata,
    input  logic                        redirect_valid,
    input  logic [XLEN-1:0]             redirect_pc,
    input  logic                        halt,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [XLEN-1:0]             out_instr,
    output logic [XLEN-1:0]             out_pc,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output fetch_state_e                dbg_state
);

    fetch_state_e state;
    fetch_state_e state_d;
    logic [XLEN-1:0] pc;
    logic            fifo_full;
    logic            fifo_empty;
    logic            space;
    logic            pop;
    logic            flush;
    fetch_entry_t    push_entry;
    fetch_entry_t    head_entry;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= BOOT;
        else     state <= state_d;
    end

    // FSM next state: one idle BOOT cycle, then halt toggles FETCH/HALTED.
    always_comb begin
        state_d = state;
        case (state)
            BOOT:    state_d = FETCH;
            FETCH:   if (halt)  state_d = HALTED;
            HALTED:  if (!halt) state_d = FETCH;
            default: state_d = BOOT;
        endcase
    end

    // FSM outputs: a redirect suppresses the fetch and flushes the FIFO in any
    // state; a fetch is only issued when the FIFO can absorb it this edge.
    always_comb begin
        space    = !fifo_full || (out_valid && out_ready);
        flush    = redirect_valid;
        pop      = out_valid && out_ready && !redirect_valid;
        imem_req = 1'b0;
        if (state == FETCH && !redirect_valid) imem_req = space;
    end

    // PC register: redirect target wins, otherwise advance on each fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc <= word_align(redirect_pc);
        end else if (imem_req) begin
            pc <= pc + XLEN'(4);
        end
    end

    // Pair the current PC with the word returned by memory this cycle.
    always_comb begin
        push_entry       = '0;
        push_entry.pc    = pc;
        push_entry.instr = imem_rdata;
    end

    if_prefetch_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .entry_t (fetch_entry_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (imem_req),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (flush),
        .head      (head_entry),
        .count     (fifo_count),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    assign imem_addr = pc;
    assign out_valid = !fifo_empty;
    assign out_pc    = head_entry.pc;
    assign out_instr = head_entry.instr;
    assign dbg_state = state;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit with a queue-based reference model.
module tb_inst_fetch_unit;

    localparam int DEPTH = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic        rv = 1'b0;
    logic [31:0] rpc = '0;
    logic        h = 1'b0;
    logic        rdy = 1'b0;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [1:0]  fifo_count;
    if_pkg::fetch_state_e dbg_state;

    int errors = 0;
    int checks = 0;

    // Instruction memory contents: an arbitrary scramble of the address.
    function automatic logic [31:0] imem_f(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign imem_rdata = imem_f(imem_addr);

    inst_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_req       (imem_req),
        .imem_rdata     (imem_rdata),
        .redirect_valid (rv),
        .redirect_pc    (rpc),
        .halt           (h),
        .out_valid      (out_valid),
        .out_ready      (rdy),
        .out_instr      (out_instr),
        .out_pc         (out_pc),
        .fifo_count     (fifo_count),
        .dbg_state      (dbg_state)
    );

    // ---------------- reference model ----------------
    // exp_q holds the PCs fetched but not yet consumed, oldest first.
    logic [31:0] exp_q[$];
    logic        m_boot;
    logic        m_halted;
    logic [31:0] m_pc;
    logic [31:0] last_pc;
    logic [31:0] last_instr;

    task automatic model_reset();
        exp_q.delete();
        m_boot     = 1'b1;
        m_halted   = 1'b0;
        m_pc       = 32'h0;
        last_pc    = 32'h0;
        last_instr = 32'h0;
    endtask

    function automatic logic model_req();
        logic room;
        room = (exp_q.size() < DEPTH) || (exp_q.size() > 0 && rdy);
        return !m_boot && !m_halted && !rv && room;
    endfunction

    // {imem_addr, imem_req, out_valid, out_pc, out_instr, fifo_count}
    function automatic logic [99:0] exp_vec();
        logic [31:0] hp;
        logic [31:0] hi;
        hp = last_pc;
        hi = last_instr;
        if (exp_q.size() > 0) begin
            hp = exp_q[0];
            hi = imem_f(exp_q[0]);
        end
        return {m_pc, model_req(), exp_q.size() > 0, hp, hi, 2'(exp_q.size())};
    endfunction

    function automatic logic [99:0] obs_vec();
        return {imem_addr, imem_req, out_valid, out_pc, out_instr, fifo_count};
    endfunction

    // ---------------- driver tasks ----------------
    // Called just after a rising edge; returns at the falling edge for sampling.
    task automatic drive(input logic rv_i, input logic [31:0] rpc_i, input logic h_i, input logic rdy_i);
        rv  = rv_i;
        rpc = rpc_i;
        h   = h_i;
        rdy = rdy_i;
        @(negedge clk);
    endtask

    // Crosses the rising edge and applies the same edge to the model.
    task automatic advance();
        logic req;
        req = model_req();
        @(posedge clk);
        if (exp_q.size() > 0) begin
            last_pc    = exp_q[0];
            last_instr = imem_f(exp_q[0]);
        end
        if (rv) begin
            exp_q.delete();
            m_pc = rpc & ~32'h3;
        end else begin
            if (exp_q.size() > 0 && rdy) void'(exp_q.pop_front());
            if (req) begin
                exp_q.push_back(m_pc);
                m_pc = m_pc + 32'h4;
            end
        end
        if (m_boot) begin
            m_boot   = 1'b0;
            m_halted = 1'b0;
        end else begin
            m_halted = h;
        end
        #1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #2;
        checks++;
        if (obs_vec() !== 100'h0) begin
            errors++;
            $display("FAIL reset_values got=%h exp=%h", obs_vec(), 100'h0);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_stream();
        for (int c = 0; c < 8; c++) begin
            drive(1'b0, 32'h0, 1'b0, 1'b1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL stream cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            advance();
        end
    endtask

    task automatic test_backpressure();
        for (int c = 0; c < 10; c++) begin
            drive(1'b0, 32'h0, 1'b0, c >= 5);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL backpressure cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            advance();
        end
    endtask

    task automatic test_redirect_full();
        for (int c = 0; c < 8; c++) begin
            drive(c == 3, 32'h0000_0043, 1'b0, c >= 4);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL redirect_full cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            advance();
        end
    endtask

    task automatic test_redirect_pop();
        for (int c = 0; c < 8; c++) begin
            drive(c == 3, 32'h0000_0101, 1'b0, c >= 3);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL redirect_pop cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            advance();
        end
    endtask

    task automatic test_halt();
        for (int c = 0; c < 10; c++) begin
            drive(1'b0, 32'h0, (c >= 1 && c < 5), 1'b1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL halt cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            advance();
        end
    endtask

    task automatic test_halt_redirect();
        for (int c = 0; c < 8; c++) begin
            drive(c == 3, 32'h0000_2222, (c < 5), 1'b0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL halt_redirect cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            advance();
        end
    endtask

    task automatic test_wrap();
        for (int c = 0; c < 7; c++) begin
            drive(c == 0, 32'hFFFF_FFF8, 1'b0, 1'b1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL wrap cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            advance();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            drive($urandom_range(0, 11) == 0, $urandom, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 3) != 0);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL random cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            advance();
        end
    endtask

    task automatic test_async_reset();
        // Keep fetching so the FIFO is occupied, then hit reset between edges.
        for (int c = 0; c < 3; c++) begin
            drive(1'b0, 32'h0, 1'b0, c != 1);
            advance();
        end
        drive(1'b0, 32'h0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, imem_addr, fifo_count, imem_req} !== {1'b0, 32'h0, 2'd0, 1'b0}) begin
            errors++;
            $display("FAIL async_reset got valid=%b addr=%h cnt=%0d req=%b exp 0/0/0/0",
                     out_valid, imem_addr, fifo_count, imem_req);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int c = 0; c < 5; c++) begin
            drive(1'b0, 32'h0, 1'b0, 1'b1);
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL after_reset cyc=%0d got=%h exp=%h", c, obs_vec(), exp_vec());
            end
            advance();
        end
    endtask

    // ---------------- sequence and final report ----------------
    initial begin
        model_reset();
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_full();
        test_redirect_pop();
        test_halt();
        test_halt_redirect();
        test_wrap();
        test_random();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
